ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_wdog.sv | 33 +++
 rtl/ifetch_unit.sv | 106 ++++++++++
 tb/tb_ifetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths and FSM state type for the instruction fetch unit.
package ifetch_pkg;
   localparam int INST_W = 18;
   localparam int ADDR_W = 12;
   localparam int CNT_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HOLD,
      ISSUE,
      FAULT
   } fetch_state_t;
endpackage

// File: rtl/ifetch_wdog.sv
// Fetch watchdog: counts consecutive un-acked FETCH cycles and flags expiry
// on the cycle that reaches TIMEOUT_CYCLES.
module ifetch_wdog
   import ifetch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic fetch_i,
   input  logic ack_i,
   input  logic redirect_i,
   output logic expire_o
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             miss;

   always_comb begin
      miss     = fetch_i && !ack_i && !redirect_i;
      cnt_d    = '0;
      expire_o = 1'b0;
      if (miss) begin
         cnt_d    = cnt_q + 1'b1;
         expire_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch FSM: one outstanding word request, hold on stall, redirect.
// Optional fetch timeout enabled by defining IFETCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | one dead cycle after reset/redirect before requesting
// FETCH | request at pc until ack
// HOLD  | word latched, waiting for stall_i to drop
// ISSUE | one-cycle valid strobe, advance pc
// FAULT | fetch timed out; wait for redirect or reset
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC       = 12'h000,
   parameter int                TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [INST_W-1:0] imem_data_i,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   output logic [INST_W-1:0] inst_o,
   output logic              inst_valid_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              fault_o
);
   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              wdog_expire;

`ifdef IFETCH_TIMEOUT_EN
   ifetch_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk        (clk),
      .rst        (rst),
      .fetch_i    (state_q == FETCH),
      .ack_i      (imem_ack_i),
      .redirect_i (redirect_i),
      .expire_o   (wdog_expire)
   );
   assign fault_o = (state_q == FAULT);
`else
   assign wdog_expire = 1'b0;
   assign fault_o     = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_out_d     = pc_out_q;
      inst_d       = inst_q;
      imem_req_o   = 1'b0;
      inst_valid_o = 1'b0;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            imem_req_o = 1'b1;
            if (imem_ack_i) begin
               inst_d   = imem_data_i;
               pc_out_d = pc_q;
               state_d  = stall_i ? HOLD : ISSUE;
            end else if (wdog_expire) begin
               state_d = FAULT;
            end
         end
         HOLD:  if (!stall_i) state_d = ISSUE;
         ISSUE: begin
            inst_valid_o = 1'b1;
            pc_d         = pc_q + 1'b1;
            state_d      = FETCH;
         end
         FAULT: state_d = FAULT;
         default: state_d = IDLE;
      endcase
      // Redirect overrides everything decided above, including a same-cycle ack.
      if (redirect_i) begin
         state_d      = IDLE;
         pc_d         = redirect_addr_i;
         pc_out_d     = pc_out_q;
         inst_d       = inst_q;
         inst_valid_o = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         pc_out_q <= RESET_PC;
         inst_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         inst_q   <= inst_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign inst_o      = inst_q;
   assign pc_o        = pc_out_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, reset/timeout sequences, and
// random stimulus checked against an issue-stream model.
module tb_ifetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_o;
   logic [11:0] imem_addr_o;
   logic        imem_ack_i;
   logic [17:0] imem_data_i;
   logic        stall_i;
   logic        redirect_i;
   logic [11:0] redirect_addr_i;
   logic [17:0] inst_o;
   logic        inst_valid_o;
   logic [11:0] pc_o;
   logic        fault_o;

   int checks = 0;
   int errors = 0;

   ifetch_unit #(.RESET_PC(12'h000), .TIMEOUT_CYCLES(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ack_i      (imem_ack_i),
      .imem_data_i     (imem_data_i),
      .stall_i         (stall_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .inst_o          (inst_o),
      .inst_valid_o    (inst_valid_o),
      .pc_o            (pc_o),
      .fault_o         (fault_o)
   );

   always #5 clk = ~clk;

   // Memory contents: word at address a is a + 0x100.
   assign imem_data_i = 18'(imem_addr_o) + 18'h100;

   function automatic logic [17:0] mem_word(input logic [11:0] a);
      return 18'(a) + 18'h100;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        stall, ack, redir;
      logic [11:0] raddr;
      logic        req, valid;
      logic [11:0] addr;
      logic [17:0] inst;
      logic [11:0] pc;
   } vec_t;

   vec_t tbl[21];

   task automatic cycle_start();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          n_fetch;
      int          n_issue;
      logic        seen_fault;
      logic        prev_valid;
      logic [11:0] exp_pc;

      //            stall ack redir raddr   req valid addr     inst      pc
      tbl[0]  = '{1'b0,1'b1,1'b0,12'h000, 1'b0,1'b0,12'h000,18'h00000,12'h000};
      tbl[1]  = '{1'b0,1'b1,1'b0,12'h000, 1'b1,1'b0,12'h000,18'h00000,12'h000};
      tbl[2]  = '{1'b0,1'b1,1'b0,12'h000, 1'b0,1'b1,12'h000,18'h00100,12'h000};
      tbl[3]  = '{1'b0,1'b1,1'b0,12'h000, 1'b1,1'b0,12'h001,18'h00100,12'h000};
      tbl[4]  = '{1'b0,1'b1,1'b0,12'h000, 1'b0,1'b1,12'h001,18'h00101,12'h001};
      tbl[5]  = '{1'b1,1'b1,1'b0,12'h000, 1'b1,1'b0,12'h002,18'h00101,12'h001};
      tbl[6]  = '{1'b1,1'b0,1'b0,12'h000, 1'b0,1'b0,12'h002,18'h00102,12'h002};
      tbl[7]  = '{1'b1,1'b0,1'b0,12'h000, 1'b0,1'b0,12'h002,18'h00102,12'h002};
      tbl[8]  = '{1'b1,1'b0,1'b0,12'h000, 1'b0,1'b0,12'h002,18'h00102,12'h002};
      tbl[9]  = '{1'b0,1'b0,1'b0,12'h000, 1'b0,1'b0,12'h002,18'h00102,12'h002};
      tbl[10] = '{1'b0,1'b0,1'b0,12'h000, 1'b0,1'b1,12'h002,18'h00102,12'h002};
      tbl[11] = '{1'b0,1'b1,1'b1,12'h0A5, 1'b1,1'b0,12'h003,18'h00102,12'h002};
      tbl[12] = '{1'b0,1'b1,1'b0,12'h000, 1'b0,1'b0,12'h0A5,18'h00102,12'h002};
      tbl[13] = '{1'b0,1'b0,1'b0,12'h000, 1'b1,1'b0,12'h0A5,18'h00102,12'h002};
      tbl[14] = '{1'b0,1'b0,1'b0,12'h000, 1'b1,1'b0,12'h0A5,18'h00102,12'h002};
      tbl[15] = '{1'b0,1'b1,1'b0,12'h000, 1'b1,1'b0,12'h0A5,18'h00102,12'h002};
      tbl[16] = '{1'b0,1'b0,1'b1,12'hFFF, 1'b0,1'b0,12'h0A5,18'h001A5,12'h0A5};
      tbl[17] = '{1'b0,1'b1,1'b0,12'h000, 1'b0,1'b0,12'hFFF,18'h001A5,12'h0A5};
      tbl[18] = '{1'b0,1'b1,1'b0,12'h000, 1'b1,1'b0,12'hFFF,18'h001A5,12'h0A5};
      tbl[19] = '{1'b0,1'b0,1'b0,12'h000, 1'b0,1'b1,12'hFFF,18'h010FF,12'hFFF};
      tbl[20] = '{1'b0,1'b0,1'b0,12'h000, 1'b1,1'b0,12'h000,18'h010FF,12'hFFF};

      rst = 1'b1; imem_ack_i = 1'b0; stall_i = 1'b0;
      redirect_i = 1'b0; redirect_addr_i = 12'h000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req",   imem_req_o,   0);
      chk("reset_valid", inst_valid_o, 0);
      chk("reset_inst",  inst_o,       0);
      chk("reset_pc",    pc_o,         0);
      chk("reset_addr",  imem_addr_o,  0);
      chk("reset_fault", fault_o,      0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed cycle table starting on the first cycle after reset release.
      for (int i = 0; i < 21; i++) begin
         if (i != 0) cycle_start();
         stall_i = tbl[i].stall; imem_ack_i = tbl[i].ack;
         redirect_i = tbl[i].redir; redirect_addr_i = tbl[i].raddr;
         @(negedge clk);
         chk($sformatf("tbl%0d_req", i),   imem_req_o,   tbl[i].req);
         chk($sformatf("tbl%0d_valid", i), inst_valid_o, tbl[i].valid);
         chk($sformatf("tbl%0d_addr", i),  imem_addr_o,  tbl[i].addr);
         chk($sformatf("tbl%0d_inst", i),  inst_o,       tbl[i].inst);
         chk($sformatf("tbl%0d_pc", i),    pc_o,         tbl[i].pc);
         chk($sformatf("tbl%0d_fault", i), fault_o,      0);
      end

      // Reset asserted mid-fetch at pc 0x033.
      cycle_start(); redirect_i = 1'b1; redirect_addr_i = 12'h033; imem_ack_i = 1'b0;
      cycle_start(); redirect_i = 1'b0;
      cycle_start();
      @(negedge clk);
      chk("midrst_pre_req",  imem_req_o,  1);
      chk("midrst_pre_addr", imem_addr_o, 12'h033);
      #2 rst = 1'b1; imem_ack_i = 1'b1;
      #1;
      chk("midrst_req",   imem_req_o,   0);
      chk("midrst_addr",  imem_addr_o,  0);
      chk("midrst_inst",  inst_o,       0);
      chk("midrst_pc",    pc_o,         0);
      chk("midrst_valid", inst_valid_o, 0);
      chk("midrst_fault", fault_o,      0);
      @(posedge clk); @(negedge clk);
      chk("midrst_hold_req",  imem_req_o, 0);
      chk("midrst_hold_inst", inst_o,     0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("postrst_idle_req",  imem_req_o, 0);
      chk("postrst_late_ack",  inst_o,     0);
      cycle_start(); @(negedge clk);
      chk("postrst_fetch_req",  imem_req_o,  1);
      chk("postrst_fetch_addr", imem_addr_o, 12'h000);
      cycle_start(); @(negedge clk);
      chk("postrst_issue_valid", inst_valid_o, 1);
      chk("postrst_issue_inst",  inst_o,       18'h00100);

      // Random stimulus against an issue-stream model.
      cycle_start(); rst = 1'b1; imem_ack_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
      cycle_start(); rst = 1'b0;
      exp_pc = 12'h000; prev_valid = 1'b0; n_issue = 0;
      for (int c = 0; c < 2000; c++) begin
         if (c != 0) cycle_start();
         imem_ack_i      = ($urandom_range(2) != 0);
         stall_i         = ($urandom_range(3) == 0);
         redirect_i      = ($urandom_range(19) == 0);
         redirect_addr_i = 12'($urandom);
         @(negedge clk);
         if (imem_req_o) chk("rnd_addr", imem_addr_o, exp_pc);
         if (redirect_i) chk("rnd_redir_nostrobe", inst_valid_o, 0);
         if (inst_valid_o) begin
            chk("rnd_pc", pc_o, exp_pc);
            chk("rnd_inst", inst_o, mem_word(exp_pc));
            chk("rnd_single_strobe", prev_valid, 0);
            n_issue++;
         end
         prev_valid = inst_valid_o;
         if (redirect_i) exp_pc = redirect_addr_i;
         else if (inst_valid_o) exp_pc = exp_pc + 12'd1;
      end
      chk("rnd_issue_activity", 32'(n_issue > 150), 1);

      // Timeout behaviour with ack held low.
      cycle_start(); redirect_i = 1'b1; redirect_addr_i = 12'h040;
      imem_ack_i = 1'b0; stall_i = 1'b0;
      @(negedge clk);
      n_fetch = 0; seen_fault = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      for (int c = 0; c < 100 && !seen_fault; c++) begin
         cycle_start(); redirect_i = 1'b0;
         @(negedge clk);
         if (fault_o) seen_fault = 1'b1;
         else if (imem_req_o) n_fetch++;
      end
      chk("tmo_fault_seen", seen_fault, 1);
      chk("tmo_fetch_cycles", n_fetch, 16);
      chk("tmo_req_dropped", imem_req_o, 0);
      cycle_start(); @(negedge clk);
      chk("tmo_fault_held", fault_o, 1);
      cycle_start(); redirect_i = 1'b1; redirect_addr_i = 12'h010;
      cycle_start(); redirect_i = 1'b0;
      @(negedge clk);
      chk("tmo_fault_cleared", fault_o, 0);
      chk("tmo_idle_req", imem_req_o, 0);
      cycle_start(); @(negedge clk);
      chk("tmo_refetch_req",  imem_req_o,  1);
      chk("tmo_refetch_addr", imem_addr_o, 12'h010);
`else
      for (int c = 0; c < 40; c++) begin
         cycle_start(); redirect_i = 1'b0;
         @(negedge clk);
         if (fault_o) seen_fault = 1'b1;
         if (imem_req_o) n_fetch++;
      end
      chk("notmo_no_fault", seen_fault, 0);
      chk("notmo_fetch_waits", n_fetch, 39);
      chk("notmo_addr", imem_addr_o, 12'h040);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
